// File: rtl/eeprom_pkg.sv
// Shared types and constants for the serial EEPROM I2C master.
// Control byte layout is {EEPROM_ID, block[2:0], rw}.
package eeprom_pkg;

   localparam int ADDR_W = 11;
   localparam int DATA_W = 8;

   localparam logic [3:0] EEPROM_ID = 4'b1010;
   localparam logic RD = 1'b1;
   localparam logic WR = 1'b0;

   typedef enum logic [3:0] {
      S_IDLE,
      S_START,
      S_CTRL,
      S_ACK1,
      S_ADDR,
      S_ACK2,
      S_WDATA,
      S_ACK3,
      S_RSTART,
      S_RCTRL,
      S_ACK4,
      S_RDATA,
      S_MNACK,
      S_STOP,
      S_DONE
   } state_t;

   function automatic logic [7:0] ctrl_byte(
      input logic [2:0] blk,
      input logic rw
   );
      return {EEPROM_ID, blk, rw};
   endfunction

   function automatic state_t ack_of(input state_t s);
      unique case (s)
         S_CTRL:  return S_ACK1;
         S_ADDR:  return S_ACK2;
         S_WDATA: return S_ACK3;
         default: return S_ACK4;
      endcase
   endfunction

endpackage

// File: rtl/i2c_qtr_timer.sv
// Divides clk into SCL quarters: stb marks the last clk of a quarter,
// phase numbers the quarter within the bit slot.
module i2c_qtr_timer #(
   parameter int QTR = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
   output logic       stb,
   output logic [1:0] phase
);

   localparam int CW = (QTR > 1) ? $clog2(QTR) : 1;
   localparam logic [CW-1:0] LAST = CW'(QTR - 1);

   logic [CW-1:0] cnt;

   assign stb = run && (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         phase <= 2'd0;
      end else if (!run) begin
         cnt   <= '0;
         phase <= 2'd0;
      end else if (cnt == LAST) begin
         cnt   <= '0;
         phase <= phase + 2'd1;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/eeprom_i2c_ctrl.sv
// I2C master for a 2 KB serial EEPROM: single-byte write and
// random-address read, with optional ACK checking.
module eeprom_i2c_ctrl
   import eeprom_pkg::*;
#(
   parameter int QTR       = 4,
   parameter bit CHECK_ACK = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic              wr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rdata,
   output logic              err,
   output logic              scl,
   inout  wire               sda
);

   state_t            state;
   logic              wr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [7:0]        sh;
   logic [2:0]        bcnt;
   logic              oe;
   logic              ack_smp;
   logic              stb;
   logic [1:0]        phase;
   logic              run;
   logic              sda_in;
   logic              nack;
   logic [7:0]        ctrl_w;
   logic [7:0]        ctrl_r;

   assign sda    = oe ? 1'b0 : 1'bz;
   assign sda_in = sda;
   assign run    = (state != S_IDLE) && (state != S_DONE);
   assign nack   = CHECK_ACK && ack_smp;
   assign ctrl_w = ctrl_byte(addr_q[10:8], WR);
   assign ctrl_r = ctrl_byte(addr_q[10:8], RD);

   i2c_qtr_timer #(
      .QTR(QTR)
   ) u_timer (
      .clk  (clk),
      .rst_n(rst_n),
      .run  (run),
      .stb  (stb),
      .phase(phase)
   );

   // Outputs are set one quarter ahead: each stb edge loads the
   // scl/oe levels of the quarter (or slot) that begins next.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         rdata   <= '0;
         err     <= 1'b0;
         scl     <= 1'b1;
         oe      <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         sh      <= '0;
         bcnt    <= 3'd0;
         ack_smp <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == S_IDLE) begin
            if (req) begin
               wr_q    <= wr;
               addr_q  <= addr;
               wdata_q <= wdata;
               err     <= 1'b0;
               busy    <= 1'b1;
               scl     <= 1'b0;
               oe      <= 1'b0;
               state   <= S_START;
            end
         end else if (state == S_DONE) begin
            state <= S_IDLE;
         end else if (stb) begin
            unique case (phase)
               2'd0: scl <= 1'b1;
               2'd1: begin
                  if (state == S_START || state == S_RSTART)
                     oe <= 1'b1;
                  else if (state == S_STOP)
                     oe <= 1'b0;
               end
               2'd2: begin
                  ack_smp <= sda_in;
                  if (state == S_RDATA)
                     rdata <= {rdata[DATA_W-2:0], sda_in};
               end
               default: begin
                  scl <= 1'b0;
                  unique case (state)
                     S_START: begin
                        state <= S_CTRL;
                        sh    <= ctrl_w;
                        bcnt  <= 3'd7;
                        oe    <= ~ctrl_w[7];
                     end
                     S_CTRL, S_ADDR, S_WDATA, S_RCTRL: begin
                        if (bcnt != 3'd0) begin
                           bcnt <= bcnt - 3'd1;
                           sh   <= {sh[6:0], 1'b0};
                           oe   <= ~sh[6];
                        end else begin
                           oe    <= 1'b0;
                           state <= ack_of(state);
                        end
                     end
                     S_ACK1: begin
                        if (nack) begin
                           err   <= 1'b1;
                           oe    <= 1'b1;
                           state <= S_STOP;
                        end else begin
                           state <= S_ADDR;
                           sh    <= addr_q[7:0];
                           bcnt  <= 3'd7;
                           oe    <= ~addr_q[7];
                        end
                     end
                     S_ACK2: begin
                        if (nack) begin
                           err   <= 1'b1;
                           oe    <= 1'b1;
                           state <= S_STOP;
                        end else if (wr_q) begin
                           state <= S_WDATA;
                           sh    <= wdata_q;
                           bcnt  <= 3'd7;
                           oe    <= ~wdata_q[7];
                        end else begin
                           oe    <= 1'b0;
                           state <= S_RSTART;
                        end
                     end
                     S_ACK3: begin
                        if (nack)
                           err <= 1'b1;
                        oe    <= 1'b1;
                        state <= S_STOP;
                     end
                     S_RSTART: begin
                        state <= S_RCTRL;
                        sh    <= ctrl_r;
                        bcnt  <= 3'd7;
                        oe    <= ~ctrl_r[7];
                     end
                     S_ACK4: begin
                        if (nack) begin
                           err   <= 1'b1;
                           oe    <= 1'b1;
                           state <= S_STOP;
                        end else begin
                           oe    <= 1'b0;
                           bcnt  <= 3'd7;
                           state <= S_RDATA;
                        end
                     end
                     S_RDATA: begin
                        oe <= 1'b0;
                        if (bcnt != 3'd0)
                           bcnt <= bcnt - 3'd1;
                        else
                           state <= S_MNACK;
                     end
                     S_MNACK: begin
                        oe    <= 1'b1;
                        state <= S_STOP;
                     end
                     S_STOP: begin
                        scl   <= 1'b1;
                        oe    <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                     end
                     default: state <= S_IDLE;
                  endcase
               end
            endcase
         end
      end
   end

endmodule

// File: doc/eeprom_i2c_ctrl.md
# eeprom_i2c_ctrl

Host-side I2C master that sequences single-byte writes and random-address reads to a 2 Kbyte serial EEPROM (8 blocks × 256 bytes, control byte 1010_bbb_r/w). Sits between the system host logic and the two-wire SCL/SDA bus. It accepts one request at a time and generates START, repeated START, STOP, control, address and data phases. It returns the read byte with a one-cycle done pulse.

## Interface
- QTR, 4: clk cycles per quarter SCL period; legal ≥1; SCL period = 4·QTR clk.
- CHECK_ACK, 0: 1 = sample slave ACK and abort on NACK; 0 = ignore the ACK bit.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req  in  1  request strobe; sampled only in IDLE.
- wr  in  1  1 = byte write, 0 = random read; captured with req.
- addr  in  11  byte address; [10:8] = block bits bbb, [7:0] = word address.
- wdata  in  8  write data; captured with req.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle pulse at transaction end.
- rdata  out  8  read byte; valid when done and ~wr; held until the next read.
- err  out  1  NACK abort flag; valid with done; cleared on the next acceptance.
- scl  out  1  bus clock.
- sda  inout  1  bus data; driven only as 0 or released (z); 1 comes from the pull-up.

## Operation
- Each bus slot has 4 quarters. Q0: scl=0, SDA changes. Q1: scl rises. Q2: scl=1, sample SDA at the end of Q2. Q3: scl held 1, falls at the Q3→Q0 boundary.
- START slot: SDA released in Q0, pulled low in Q2. STOP slot: SDA low in Q0, released in Q2.
- Control byte = {4'b1010, addr[10:8], rw}, sent MSB first.
- FSM for a write: IDLE → START → CTRL(8) → ACK1 → ADDR(8) → ACK2 → WDATA(8) → ACK3 → STOP → DONE → IDLE.
- FSM for a read: IDLE → START → CTRL(rw=0) → ACK1 → ADDR → ACK2 → RSTART → RCTRL(rw=1) → ACK4 → RDATA(8) → MNACK → STOP → DONE → IDLE.
- ACKx slots: SDA released; the level is sampled at the end of Q2. If CHECK_ACK=1 and the sample is 1, set err and go directly to STOP.
- RDATA: SDA released; bits are shifted into rdata MSB first at each Q2 sample. MNACK: master releases SDA, so the bit reads as 1.
- A 3-bit bit counter counts 7→0 within each byte state. A quarter counter of width clog2(QTR) plus a 2-bit phase counter generate the quarters.
- req while busy is ignored; there is no queue. addr, wdata and wr are latched at acceptance and input changes afterwards are ignored.
- Address wrap and page behaviour are the slave's concern; the controller passes addr through unchanged.

## Timing
- Reset values: scl=1, SDA released, busy=0, done=0, rdata=8'h00, err=0, FSM=IDLE.
- Acceptance: req=1 in IDLE at edge n → busy=1 at n+1; START Q0 begins at n+1.
- Write length: 29 slots (1 START + 27 bits + 1 STOP) = 116·QTR clk. done=1 in the single cycle after the STOP slot ends; busy falls in the same cycle.
- Read length: 39 slots = 156·QTR clk, then done.
- NACK abort: STOP starts in the slot after the failing ACK slot; done and err follow the STOP slot.
- Reset mid-transaction: all outputs return to reset values immediately (asynchronous). No STOP is generated. The slave is resynchronised by the next START.
- The bus is idle (scl=1, SDA released) in IDLE and DONE.

## Structure
- Shared package eeprom_pkg: EEPROM_ID = 4'b1010, RD=1/WR=0 bit constants, FSM state enum, ADDR_W=11, DATA_W=8.
- One sub-module, i2c_qtr_timer: divides clk by QTR and outputs a quarter strobe plus a 2-bit phase. The top level holds the FSM, shift registers and SDA output enable.

## Test plan
- Reset: rst_n=0 → scl=1, SDA=z, busy=0, done=0, rdata=0.
- Write addr=11'h5A3, wdata=8'hC4, QTR=4 → bus shows START, control 8'hAA, address 8'hA3, data 8'hC4, STOP. The bench's EEPROM model memory[0x5A3]=0xC4. done occurs 464 clk after acceptance.
- Read addr=11'h5A3 after the write above → bus shows control 8'hAA, address 8'hA3, repeated START, control 8'hAB, NACK, STOP. rdata=8'hC4 with done; total 624 clk.
- CHECK_ACK=1 with the slave not acknowledging the control byte → err=1. STOP follows ACK1 and done arrives after 11 slots. No address byte appears on the bus.
- req pulsed again while busy (wr=1, addr=0) → ignored. Only the first transaction appears on the bus and exactly one done pulse is produced.
- rst_n asserted during the ADDR phase → scl=1 and SDA=z in the same cycle. A subsequent write to addr=11'h000 with wdata=8'h11 completes normally and memory[0]=0x11.
